tt_sweep_characterizer: RTL and testbench
=========================================

Name: tt_sweep_characterizer

Overview:
- Parametrised sequential truth-table characterizer for N-input single-output combinational gate netlists, such as the NOT/NOR structural designs used in circuit-score testing.
- Steps an external device-under-characterization (DUC) through all 2^N_IN input vectors and waits a settle interval per vector.
- Samples the DUC output and assembles the observed truth table, then compares it against an expected truth-table word.
- Sits on the bench/scoring side, next to the generated netlists.

Parameters:
- N_IN, 3, number of DUC inputs (1..6); truth-table width TT_W = 2**N_IN.
- SETTLE_CYCLES, 4, cycles each vector is held before sampling (1..255).
- CNT_W, N_IN+1, width of the mismatch counter (holds 0..TT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a sweep; accepted only in IDLE.
- abort  in  1  terminate a running sweep.
- expected_tt  in  TT_W  expected truth table; bit i = output for input vector i; captured on start acceptance.
- dut_in  out  N_IN  vector driven to the DUC.
- dut_out  in  1  DUC output.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on sweep completion.
- observed_tt  out  TT_W  assembled truth table.
- mismatch_cnt  out  CNT_W  popcount(observed_tt XOR expected).
- first_mismatch  out  N_IN  lowest mismatching index; 0 if none.
- pass  out  1  mismatch_cnt==0; valid after done.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE.
  - dut_in, busy, done, observed_tt, mismatch_cnt, first_mismatch, pass all 0.
  - Captured expected register 0.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - start=1 → capture expected_tt, clear observed_tt/mismatch_cnt/first_mismatch/pass.
  - Load idx=0 and settle counter=SETTLE_CYCLES; go to SETTLE.
  - busy=1 from the next cycle.
- SETTLE:
  - dut_in=idx held stable.
  - Counter decrements each cycle; at 1 → SAMPLE.
  - Each vector spends exactly SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (1 cycle):
  - observed_tt[idx] <= dut_out.
  - If dut_out != expected[idx]: mismatch_cnt++; if this is the first mismatch, first_mismatch <= idx.
  - If idx==TT_W-1 → FINISH; else idx++, reload counter, → SETTLE.
- FINISH (1 cycle):
  - pass <= (mismatch_cnt==0), including the last sample's update.
  - done=1 for this cycle; next state IDLE; busy deasserts in the same cycle done is seen.
- Latency:
  - start accepted at edge T → done high in cycle T + TT_W*(SETTLE_CYCLES+1) + 1.
  - N_IN=3, SETTLE_CYCLES=4: done in cycle T+41.
- dut_in holds its last driven value in IDLE (no return to 0).
- start while busy: ignored. Expected register is not re-captured.
- abort while busy, any non-IDLE state: next cycle IDLE, busy=0, done not pulsed, pass=0, partial observed_tt/mismatch_cnt retained. abort in IDLE: no effect.
- abort and start asserted together in IDLE: start wins.
- Reset mid-sweep: immediate clear to reset values; no done.
- Outputs remain stable in IDLE until the next accepted start.
- mismatch_cnt saturates naturally at TT_W; no wrap possible given CNT_W.

Optional Feature:
- Macro: TT_SWEEP_CHARACTERIZER_STABILITY_EN.
- When defined:
  - Adds output `unstable` (1 bit) and `unstable_tt` (TT_W).
  - During the last ceil(SETTLE_CYCLES/2) SETTLE cycles of each vector, any change in dut_out versus the previous cycle sets unstable_tt[idx].
  - unstable = OR of unstable_tt, updated in FINISH.
  - Both are cleared on start acceptance and on reset.
- When undefined: ports absent; no stability logic.

Decomposition:
- Shared package tt_char_pkg:
  - FSM state enum.
  - Function tt_width(n) = 2**n.
  - Popcount helper.
  - Constants for reference functions, e.g. TT_0x89 = 8'h89.
- One natural sub-module, tt_settle_counter: loadable down-counter with terminal flag. All else stays in the top module.

Test Plan:
- DUC model realising 0x89 (N_IN=3), expected 8'h89, SETTLE_CYCLES=4 → done at T+41, observed_tt=8'h89, mismatch_cnt=0, pass=1.
- Same DUC, expected 8'h88 → observed_tt=8'h89, mismatch_cnt=1, first_mismatch=0, pass=0.
- Inverted DUC (~0x89 = 8'h76), expected 8'h89 → mismatch_cnt=8, first_mismatch=0, pass=0.
- start pulsed again at T+10 with expected 8'h00 → ignored; results still compare against 8'h89; single done pulse.
- abort at T+15 → busy low at T+16, no done; observed_tt bits 0..2 valid; new start then completes normally. rst_n low at T+20 → all outputs 0 immediately.
- STABILITY_EN: DUC output toggles at the last settle cycle of vector 5 → unstable_tt=8'h20, unstable=1.

Source files
------------

// File: rtl/tt_char_pkg.sv
// rtl/tt_char_pkg.sv - shared types, width helper and reference truth tables for the sweep characterizer
package tt_char_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tt_state_e;

    localparam logic [7:0] TT_0x89 = 8'h89;
    localparam logic [7:0] TT_NOT_0x89 = 8'h76;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// rtl/tt_settle_counter.sv - loadable down-counter with terminal flag; window output with TT_SWEEP_CHARACTERIZER_STABILITY_EN
module tt_settle_counter #(
    parameter int W      = 8,
    parameter int WINDOW = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         terminal
`ifdef TT_SWEEP_CHARACTERIZER_STABILITY_EN
    ,
    output logic         window
`endif
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign terminal = (count == W'(1));

`ifdef TT_SWEEP_CHARACTERIZER_STABILITY_EN
    // Counter runs down to 1, so the final WINDOW settle cycles are count in 1..WINDOW.
    assign window = (count != '0) && (count <= W'(WINDOW));
`endif

endmodule

// File: rtl/tt_sweep_characterizer.sv
// rtl/tt_sweep_characterizer.sv - sweeps a DUC through all input vectors and scores its truth table
// Optional glitch detection under TT_SWEEP_CHARACTERIZER_STABILITY_EN.
module tt_sweep_characterizer
    import tt_char_pkg::*;
#(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = N_IN + 1,
    localparam int TT_W         = tt_width(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [TT_W-1:0]  expected_tt,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  observed_tt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [N_IN-1:0]  first_mismatch,
    output logic             pass
`ifdef TT_SWEEP_CHARACTERIZER_STABILITY_EN
    ,
    output logic             unstable,
    output logic [TT_W-1:0]  unstable_tt
`endif
);

    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

    tt_state_e         state;
    logic [N_IN-1:0]   idx;
    logic [TT_W-1:0]   exp_q;
    logic              settle_last;
    logic              cnt_load;
    logic              accept;
    logic              sample_miss;
    logic [CNT_W-1:0]  mis_next;

    assign accept      = (state == ST_IDLE) && start;
    assign cnt_load    = accept || ((state == ST_SAMPLE) && (idx != LAST_IDX));
    assign sample_miss = (dut_out != exp_q[idx]);
    assign mis_next    = mismatch_cnt + CNT_W'(sample_miss);
    assign dut_in      = idx;

`ifdef TT_SWEEP_CHARACTERIZER_STABILITY_EN
    logic settle_window;
    logic dut_out_q;

    tt_settle_counter #(.W(8), .WINDOW((SETTLE_CYCLES + 1) / 2)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (8'(SETTLE_CYCLES)),
        .en       (state == ST_SETTLE),
        .terminal (settle_last),
        .window   (settle_window)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_out_q   <= 1'b0;
            unstable_tt <= '0;
            unstable    <= 1'b0;
        end else begin
            dut_out_q <= dut_out;
            if (accept) begin
                unstable_tt <= '0;
                unstable    <= 1'b0;
            end else if (state == ST_SETTLE && settle_window && dut_out != dut_out_q) begin
                unstable_tt[idx] <= 1'b1;
            end else if (state == ST_SAMPLE && idx == LAST_IDX && !abort) begin
                unstable <= |unstable_tt;
            end
        end
    end
`else
    tt_settle_counter #(.W(8), .WINDOW(1)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (8'(SETTLE_CYCLES)),
        .en       (state == ST_SETTLE),
        .terminal (settle_last)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            exp_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            observed_tt    <= '0;
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
            pass           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q          <= expected_tt;
                        observed_tt    <= '0;
                        mismatch_cnt   <= '0;
                        first_mismatch <= '0;
                        pass           <= 1'b0;
                        idx            <= '0;
                        busy           <= 1'b1;
                        state          <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (settle_last) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // The sample is recorded even on an abort edge; only the sequencing stops.
                    observed_tt[idx] <= dut_out;
                    mismatch_cnt     <= mis_next;
                    if (sample_miss && mismatch_cnt == '0) begin
                        first_mismatch <= idx;
                    end
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (idx == LAST_IDX) begin
                        state <= ST_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mis_next == '0);
                    end else begin
                        idx   <= idx + N_IN'(1);
                        state <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_characterizer.sv
// tb/tb_tt_sweep_characterizer.sv - table-driven and randomized checks of tt_sweep_characterizer
module tb_tt_sweep_characterizer;
    import tt_char_pkg::*;

    localparam int N_IN  = 3;
    localparam int SC    = 4;
    localparam int TT_W  = 8;
    localparam int CNT_W = 4;
    localparam int SWEEP = TT_W * (SC + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [TT_W-1:0]  expected_tt = '0;
    logic [N_IN-1:0]  dut_in;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic [TT_W-1:0]  observed_tt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [N_IN-1:0]  first_mismatch;
    logic             pass;
`ifdef TT_SWEEP_CHARACTERIZER_STABILITY_EN
    logic             unstable;
    logic [TT_W-1:0]  unstable_tt;
`endif

    logic [7:0] duc_tt = TT_0x89;
    logic       glitch = 1'b0;
    assign dut_out = duc_tt[dut_in] ^ glitch;

    always #5 clk = ~clk;

    tt_sweep_characterizer #(.N_IN(N_IN), .SETTLE_CYCLES(SC), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .expected_tt    (expected_tt),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .observed_tt    (observed_tt),
        .mismatch_cnt   (mismatch_cnt),
        .first_mismatch (first_mismatch),
        .pass           (pass)
`ifdef TT_SWEEP_CHARACTERIZER_STABILITY_EN
        ,
        .unstable       (unstable),
        .unstable_tt    (unstable_tt)
`endif
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    // Reference: score the first nbits entries of the observed table against the expected one.
    function automatic int ref_cnt(input logic [7:0] obs, input logic [7:0] exp_w, input int nbits);
        int c = 0;
        for (int i = 0; i < nbits; i++) if (obs[i] != exp_w[i]) c++;
        return c;
    endfunction

    function automatic int ref_first(input logic [7:0] obs, input logic [7:0] exp_w, input int nbits);
        for (int i = 0; i < nbits; i++) if (obs[i] != exp_w[i]) return i;
        return 0;
    endfunction

    typedef struct {
        logic [7:0] duc;
        logic [7:0] exp_w;
        logic [7:0] obs;
        int         cnt;
        int         first;
        logic       pass_e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.duc    = d;
        v.exp_w  = e;
        v.obs    = d;
        v.cnt    = ref_cnt(d, e, 8);
        v.first  = ref_first(d, e, 8);
        v.pass_e = (v.cnt == 0);
        return v;
    endfunction

    function automatic vec_t mk_fixed(input logic [7:0] d, input logic [7:0] e, input logic [7:0] o,
                                      input int c, input int f, input logic p);
        vec_t v;
        v.duc = d; v.exp_w = e; v.obs = o; v.cnt = c; v.first = f; v.pass_e = p;
        return v;
    endfunction

    // Drives one start (optionally with abort) and waits for done; lat counts edges after acceptance.
    task automatic run_sweep(input logic [7:0] exp_w, input logic with_abort,
                             output int lat, output logic busy0);
        @(negedge clk);
        start = 1'b1; abort = with_abort; expected_tt = exp_w;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; expected_tt = 8'($urandom);
        busy0 = busy;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   ndone;
        int   done_at;
        logic b0;
        logic [7:0] r, e;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_observed", observed_tt, 0);
        chk("reset_mismatch", mismatch_cnt, 0);
        chk("reset_first", first_mismatch, 0);
        chk("reset_pass", pass, 0);
        chk("reset_dut_in", dut_in, 0);
        rst_n = 1'b1;

        vecs.push_back(mk_fixed(TT_0x89, 8'h89, 8'h89, 0, 0, 1'b1));
        vecs.push_back(mk_fixed(TT_0x89, 8'h88, 8'h89, 1, 0, 1'b0));
        vecs.push_back(mk_fixed(TT_NOT_0x89, 8'h89, 8'h76, 8, 0, 1'b0));
        vecs.push_back(mk_fixed(TT_0x89, 8'h09, 8'h89, 1, 7, 1'b0));
        vecs.push_back(mk_fixed(8'h00, 8'h10, 8'h00, 1, 4, 1'b0));
        for (int k = 0; k < 8; k++) begin
            r = 8'($urandom);
            e = ($urandom_range(0, 2) == 0) ? r : (r ^ 8'($urandom) & 8'($urandom));
            vecs.push_back(mk(r, e));
        end

        foreach (vecs[i]) begin
            duc_tt = vecs[i].duc;
            run_sweep(vecs[i].exp_w, 1'b0, lat, b0);
            chk($sformatf("v%0d_busy_after_start", i), b0, 1);
            chk($sformatf("v%0d_latency", i), lat, SWEEP);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            chk($sformatf("v%0d_observed", i), observed_tt, vecs[i].obs);
            chk($sformatf("v%0d_mismatch", i), mismatch_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_first", i), first_mismatch, vecs[i].first);
            chk($sformatf("v%0d_pass", i), pass, vecs[i].pass_e);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
        end

        // Second start mid-sweep with a different table must be ignored.
        duc_tt = TT_0x89;
        @(negedge clk);
        start = 1'b1; expected_tt = 8'h89;
        @(posedge clk);
        ndone = 0; done_at = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = (c == 9);
            expected_tt = (c == 9) ? 8'h00 : 8'h5a;
            if (done) begin
                ndone++;
                done_at = c;
            end
        end
        chk("restart_ignored_ndone", ndone, 1);
        chk("restart_ignored_done_at", done_at, SWEEP);
        chk("restart_ignored_mismatch", mismatch_cnt, 0);
        chk("restart_ignored_pass", pass, 1);

        // Abort after three vectors have been sampled.
        r = 8'($urandom); e = ~r ^ 8'($urandom);
        duc_tt = r;
        @(negedge clk);
        start = 1'b1; expected_tt = e;
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            abort = (c == 14);
            if (c == 14) chk("abort_busy_before", busy, 1);
            if (c == 15) chk("abort_busy_low", busy, 0);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_partial_observed", observed_tt, r & 8'h07);
        chk("abort_partial_mismatch", mismatch_cnt, ref_cnt(r, e, 3));
        chk("abort_partial_first", first_mismatch, ref_first(r, e, 3));
        chk("abort_pass", pass, 0);

        duc_tt = TT_0x89;
        run_sweep(8'h89, 1'b0, lat, b0);
        chk("post_abort_latency", lat, SWEEP);
        chk("post_abort_pass", pass, 1);

        // Abort in IDLE leaves results untouched; abort with start in IDLE lets start win.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_observed", observed_tt, 8'h89);
        chk("idle_abort_pass", pass, 1);
        duc_tt = TT_NOT_0x89;
        run_sweep(8'h89, 1'b1, lat, b0);
        chk("start_abort_busy", b0, 1);
        chk("start_abort_latency", lat, SWEEP);
        chk("start_abort_mismatch", mismatch_cnt, 8);

        // Reset mid-sweep clears everything immediately.
        @(negedge clk);
        start = 1'b1; expected_tt = 8'h89;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, pass, observed_tt, mismatch_cnt, first_mismatch, dut_in}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (50) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("post_reset_idle", ndone, 0);

`ifdef TT_SWEEP_CHARACTERIZER_STABILITY_EN
        // Glitch in the last settle cycle of vector 5 only.
        duc_tt = TT_0x89;
        @(negedge clk);
        start = 1'b1; expected_tt = 8'h89;
        @(posedge clk);
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            glitch = (c == 28);
        end
        chk("stab_unstable_tt", unstable_tt, 8'h20);
        chk("stab_unstable", unstable, 1);
        chk("stab_observed", observed_tt, 8'h89);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
